// File: rtl/sweep_pkg.sv
// ============================================================================
// Module      : sweep_pkg
// Description : Shared types, constants and MISR step function for sweep
//               controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    localparam logic [15:0] c_DEFAULT_POLY = 16'h1021;

    // Operands are carried at 32 bits; msb selects the feedback tap for the
    // caller's signature width and the caller truncates the result.
    function automatic logic [31:0] misr_next(
        input logic [31:0] sig,
        input logic [31:0] data,
        input logic [31:0] poly,
        input logic [4:0]  msb
    );
        logic [31:0] fb;
        fb = sig[msb] ? poly : 32'd0;
        return (sig << 1) ^ fb ^ data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sweep_misr.sv
// ============================================================================
// Module      : sweep_misr
// Description : Multiple-input signature register with synchronous clear and
//               update enable; clear wins over enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_misr
    import sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               OUT_W = 1,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(c_DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [OUT_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;

    assign w_sig_next = SIG_W'(misr_next(32'(r_sig), 32'(i_data), 32'(POLY), 5'(SIG_W - 1)));
    assign o_sig      = r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= w_sig_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sweep_stim_ctrl.sv
// ============================================================================
// Module      : sweep_stim_ctrl
// Description : Exhaustive ascending input sweep with per-pattern settle and
//               MISR compaction of the sampled response. Optional golden
//               signature compare enabled by defining GOLDEN_CMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_stim_ctrl
    import sweep_pkg::*;
#(
    parameter int               N_IN   = 5,
    parameter int               OUT_W  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(c_DEFAULT_POLY)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  pat_o,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic             sample_valid,
    output logic [N_IN-1:0]  sample_pat,
    output logic [OUT_W-1:0] sample_data,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
`ifdef GOLDEN_CMP_EN
    ,
    input  logic [SIG_W-1:0] golden_sig,
    output logic             mismatch
`endif
);

    localparam int                 c_CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SETTLE - 1);

    sweep_state_t       r_state;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_start_ok;
    logic w_sample_ok;
    logic w_last;

    assign w_start_ok  = !abort && start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_sample_ok = !abort && (r_state == ST_SAMPLE);
    assign w_last      = (pat_o == {N_IN{1'b1}});

    sweep_misr #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_misr (
        .clk    (CK),
        .rst_n  (reset),
        .i_clr  (w_start_ok),
        .i_en   (w_sample_ok),
        .i_data (dut_out_i),
        .o_sig  (signature)
    );

`ifdef GOLDEN_CMP_EN
    // The signature is updated on the same edge that enters DONE, so the
    // compare must look at the value being loaded, not the current one.
    logic [SIG_W-1:0] w_sig_next;
    assign w_sig_next = SIG_W'(misr_next(32'(signature), 32'(dut_out_i), 32'(POLY), 5'(SIG_W - 1)));
`endif

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            pat_o        <= '0;
            sample_valid <= 1'b0;
            sample_pat   <= '0;
            sample_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef GOLDEN_CMP_EN
            mismatch     <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                pat_o   <= '0;
                busy    <= 1'b0;
                done    <= 1'b0;
`ifdef GOLDEN_CMP_EN
                mismatch <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            r_state <= ST_SETTLE;
                            pat_o   <= '0;
                            r_cnt   <= c_CNT_LOAD;
                            busy    <= 1'b1;
                            done    <= 1'b0;
`ifdef GOLDEN_CMP_EN
                            mismatch <= 1'b0;
`endif
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        sample_valid <= 1'b1;
                        sample_pat   <= pat_o;
                        sample_data  <= dut_out_i;
                        // Terminal pattern is caught before incrementing, so
                        // pat_o never wraps.
                        if (w_last) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`ifdef GOLDEN_CMP_EN
                            mismatch <= (w_sig_next != golden_sig);
`endif
                        end else begin
                            r_state <= ST_SETTLE;
                            pat_o   <= pat_o + N_IN'(1);
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sweep_stim_ctrl.sv
// ============================================================================
// Module      : tb_sweep_stim_ctrl
// Description : Scoreboard bench for sweep_stim_ctrl (default 5-input sweep
//               plus a 2-input, 3-cycle-settle instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sweep_stim_ctrl;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic        reset, start, abort, start2, abort2;
    int          mode;

    logic [4:0]  pat_o, sample_pat;
    logic        dut_out, sample_valid, sample_data, busy, done;
    logic [15:0] signature;

    logic [1:0]  pat2, sample_pat2;
    logic        dut_out2, sample_valid2, sample_data2, busy2, done2;
    logic [15:0] signature2;

`ifdef GOLDEN_CMP_EN
    logic [15:0] golden_sig, golden_sig2;
    logic        mismatch, mismatch2;
`endif

    assign dut_out  = (mode == 0) ? 1'b0 : (mode == 1) ? (pat_o == 5'd31) : 1'b1;
    assign dut_out2 = pat2[0];

    sweep_stim_ctrl #(.N_IN(5), .OUT_W(1), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)) u_dut (
        .CK(CK), .reset(reset), .start(start), .abort(abort),
        .pat_o(pat_o), .dut_out_i(dut_out),
        .sample_valid(sample_valid), .sample_pat(sample_pat), .sample_data(sample_data),
        .busy(busy), .done(done), .signature(signature)
`ifdef GOLDEN_CMP_EN
        , .golden_sig(golden_sig), .mismatch(mismatch)
`endif
    );

    sweep_stim_ctrl #(.N_IN(2), .OUT_W(1), .SETTLE(3), .SIG_W(16), .POLY(16'h1021)) u_dut2 (
        .CK(CK), .reset(reset), .start(start2), .abort(abort2),
        .pat_o(pat2), .dut_out_i(dut_out2),
        .sample_valid(sample_valid2), .sample_pat(sample_pat2), .sample_data(sample_data2),
        .busy(busy2), .done(done2), .signature(signature2)
`ifdef GOLDEN_CMP_EN
        , .golden_sig(golden_sig2), .mismatch(mismatch2)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    int q_pat[$];
    int q_dat[$];
    int q2_pat[$];
    int q2_dat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        n[0] = n[0] ^ d;
        return n;
    endfunction

    function automatic int model_data(input int m, input int p);
        if (m == 0) return 0;
        if (m == 1) return (p == 31) ? 1 : 0;
        return 1;
    endfunction

    // Monitors: pop expected samples whenever a DUT presents one.
    int ep, ed, ep2, ed2;
    always @(negedge CK) begin
        if (sample_valid) begin
            if (q_pat.size() == 0) begin
                check("unexpected_sample", 32'(sample_pat), 32'hFFFF_FFFF);
            end else begin
                ep = q_pat.pop_front();
                ed = q_dat.pop_front();
                check("sample_pat", 32'(sample_pat), 32'(ep));
                check("sample_data", 32'(sample_data), 32'(ed));
            end
        end
    end

    always @(negedge CK) begin
        if (sample_valid2) begin
            if (q2_pat.size() == 0) begin
                check("unexpected_sample2", 32'(sample_pat2), 32'hFFFF_FFFF);
            end else begin
                ep2 = q2_pat.pop_front();
                ed2 = q2_dat.pop_front();
                check("sample_pat2", 32'(sample_pat2), 32'(ep2));
                check("sample_data2", 32'(sample_data2), 32'(ed2));
            end
        end
    end

    task automatic start1(input int npush);
        for (int p = 0; p < npush; p++) begin
            q_pat.push_back(p);
            q_dat.push_back(model_data(mode, p));
        end
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge CK);
            #1;
            n++;
        end
    endtask

    logic [15:0] model;
    logic [15:0] saved;
    int          n, held_err, sv_cnt, seen;

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0; mode = 0;
`ifdef GOLDEN_CMP_EN
        golden_sig = 16'h0000; golden_sig2 = 16'h0000;
`endif
        #2;
        check("reset_outputs", 32'({pat_o, sample_valid, sample_pat, sample_data, busy, done, signature}), 32'd0);
        check("reset_outputs2", 32'({pat2, sample_valid2, sample_pat2, sample_data2, busy2, done2, signature2}), 32'd0);
        #10 reset = 1'b1;
        repeat (2) @(posedge CK);

        // All-zero response
        mode = 0;
        start1(32);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_pat_after_start", 32'(pat_o), 32'd0);
        wait_done1(n);
        check("t1_done_latency", 32'(n), 32'd64);
        check("t1_signature", 32'(signature), 32'h0000);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        @(negedge CK); #1;
        check("t1_queue_drained", 32'(q_pat.size()), 32'd0);

        // Response high only on the terminal pattern; restart from DONE
        mode = 1;
        start1(32);
        wait_done1(n);
        check("t2_done_latency", 32'(n), 32'd64);
        check("t2_signature", 32'(signature), 32'h0001);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        @(negedge CK); #1;
        check("t2_queue_drained", 32'(q_pat.size()), 32'd0);

        // All-ones response, then identical rerun
        mode = 2;
        model = 16'h0000;
        for (int i = 0; i < 32; i++) model = misr_step(model, 1'b1);
        start1(32);
        check("t3_sig_cleared", 32'(signature), 32'd0);
        wait_done1(n);
        check("t3_signature", 32'(signature), 32'(model));
        saved = signature;
        start1(32);
        wait_done1(n);
        check("t3_done_latency_rerun", 32'(n), 32'd64);
        check("t3_signature_rerun", 32'(signature), 32'(saved));
        @(negedge CK); #1;
        check("t3_queue_drained", 32'(q_pat.size()), 32'd0);

        // Second instance: 4-cycle hold per pattern, starts while busy ignored
        model = 16'h0000;
        for (int p = 0; p < 4; p++) begin
            q2_pat.push_back(p);
            q2_dat.push_back(p & 1);
            model = misr_step(model, p[0]);
        end
        @(negedge CK);
        start2 = 1'b1;
        @(posedge CK);
        #1 start2 = 1'b0;
        n = 0; held_err = 0;
        while (!done2 && n < 100) begin
            @(posedge CK);
            #1;
            n++;
            start2 = (n == 5 || n == 9);
            if (!done2 && pat2 != 2'(n / 4)) held_err++;
        end
        start2 = 1'b0;
        check("t4_done_latency", 32'(n), 32'd16);
        check("t4_pattern_hold", 32'(held_err), 32'd0);
        check("t4_signature", 32'(signature2), 32'(model));
        check("t4_busy", 32'(busy2), 32'd0);
        @(negedge CK); #1;
        check("t4_queue_drained", 32'(q2_pat.size()), 32'd0);

        // Abort after the 10th sample
        mode = 2;
        model = 16'h0000;
        for (int i = 0; i < 10; i++) model = misr_step(model, 1'b1);
        start1(10);
        n = 0; sv_cnt = 0;
        while (sv_cnt < 10 && n < 100) begin
            @(posedge CK);
            #1;
            n++;
            if (sample_valid) sv_cnt++;
        end
        abort = 1'b1;
        @(posedge CK);
        #1 abort = 1'b0;
        check("t5_busy_after_abort", 32'(busy), 32'd0);
        check("t5_pat_after_abort", 32'(pat_o), 32'd0);
        check("t5_sig_retained", 32'(signature), 32'(model));
        seen = 0;
        repeat (20) begin
            @(posedge CK);
            #1;
            if (done) seen = 1;
        end
        check("t5_done_never", 32'(seen), 32'd0);
        check("t5_queue_drained", 32'(q_pat.size()), 32'd0);

        // Asynchronous reset in the middle of SETTLE
        mode = 2;
        start1(3);
        repeat (8) @(posedge CK);
        #1;
        check("t6_busy_before_reset", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_reset_outputs", 32'({pat_o, sample_valid, sample_pat, sample_data, busy, done, signature}), 32'd0);
        @(posedge CK);
        #3 reset = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        check("t6_queue_drained", 32'(q_pat.size()), 32'd0);

`ifdef GOLDEN_CMP_EN
        mode = 1;
        golden_sig = 16'h0001;
        start1(32);
        wait_done1(n);
        check("t7_mismatch_match", 32'(mismatch), 32'd0);
        golden_sig = 16'h0002;
        start1(32);
        check("t7_mismatch_cleared", 32'(mismatch), 32'd0);
        wait_done1(n);
        check("t7_mismatch_diff", 32'(mismatch), 32'd1);
        @(negedge CK); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
